// File: rtl/adder_ctrl_if.sv
// Bundle between the AXI4-Lite register bank and adder_ctrl: start/clear
// strobes and operands in; busy, register-bank write port and sticky flags out.
interface adder_ctrl_if #(
  parameter int DATA_W = 32
);
  // Strobes are single-cycle pulses with no ready. The write port also has no
  // acknowledge: o_wr_en qualifies o_wr_addr/o_wr_data for exactly one cycle.
  logic              i_start;
  logic              i_sub;
  logic [DATA_W-1:0] i_op_a;
  logic [DATA_W-1:0] i_op_b;
  logic              i_clear;
  logic              o_is_busy;
  logic              o_wr_en;
  logic [7:0]        o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_done;
  logic              o_carry;
  logic              o_ovf;
  logic              o_irq;
  logic [1:0]        o_dbg_state;

  modport master (
    output i_start, i_sub, i_op_a, i_op_b, i_clear,
    input  o_is_busy, o_wr_en, o_wr_addr, o_wr_data,
    input  o_done, o_carry, o_ovf, o_irq, o_dbg_state
  );

  modport slave (
    input  i_start, i_sub, i_op_a, i_op_b, i_clear,
    output o_is_busy, o_wr_en, o_wr_addr, o_wr_data,
    output o_done, o_carry, o_ovf, o_irq, o_dbg_state
  );
endinterface

// File: rtl/adder_ctrl.sv
// Chunked add/subtract sequencer that writes RESULT then STATUS into the register
// bank. Define ADDER_CTRL_IRQ_EN to get a sticky completion interrupt on o_irq.
module adder_ctrl #(
  parameter int         DATA_W      = 32,
  parameter int         CHUNK_W     = 8,
  parameter logic [7:0] RESULT_ADDR = 8'h10,
  parameter logic [7:0] STATUS_ADDR = 8'h04
) (
  input logic         ACLK,
  input logic         ARSTn,
  adder_ctrl_if.slave bus
);

  localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
  localparam int KW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_CHUNKS - 1);

  if (((DATA_W % CHUNK_W) != 0) || (DATA_W > 32)) begin : g_param_check
    $error("adder_ctrl: DATA_W must be a multiple of CHUNK_W and no wider than 32");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADD     = 2'd1,
    S_WB_RES  = 2'd2,
    S_WB_STAT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                cin_q, cin_d;
  logic [KW-1:0]       k_q, k_d;
  logic                done_q, done_d;
  logic                flag_carry_q, flag_carry_d;
  logic                ovf_q, ovf_d;

  logic [CHUNK_W-1:0]  a_slice;
  logic [CHUNK_W-1:0]  b_slice;
  logic [CHUNK_W:0]    slice_sum;
  logic                ovf_w;

  assign a_slice   = a_q[k_q*CHUNK_W +: CHUNK_W];
  assign b_slice   = b_q[k_q*CHUNK_W +: CHUNK_W];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK_W{1'b0}}, cin_q};
  // b_q already holds ~B for subtract, so this one formula covers both ops.
  assign ovf_w     = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (res_q[DATA_W-1] != a_q[DATA_W-1]);

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      cin_q        <= 1'b0;
      k_q          <= '0;
      done_q       <= 1'b0;
      flag_carry_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      cin_q        <= cin_d;
      k_q          <= k_d;
      done_q       <= done_d;
      flag_carry_q <= flag_carry_d;
      ovf_q        <= ovf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    cin_d        = cin_q;
    k_d          = k_q;
    done_d       = done_q;
    flag_carry_d = flag_carry_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          a_d     = DATA_W'(bus.i_op_a);
          b_d     = bus.i_sub ? ~DATA_W'(bus.i_op_b) : DATA_W'(bus.i_op_b);
          cin_d   = bus.i_sub;
          res_d   = '0;
          k_d     = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        res_d[k_q*CHUNK_W +: CHUNK_W] = slice_sum[CHUNK_W-1:0];
        cin_d = slice_sum[CHUNK_W];
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_WB_RES;
        end
      end
      S_WB_RES: begin
        state_d = S_WB_STAT;
      end
      S_WB_STAT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Clear first so that a completion in the same cycle overrides it.
    if (bus.i_clear) begin
      done_d       = 1'b0;
      flag_carry_d = 1'b0;
      ovf_d        = 1'b0;
    end
    if (state_q == S_WB_STAT) begin
      done_d       = 1'b1;
      flag_carry_d = cin_q;
      ovf_d        = ovf_w;
    end
  end

  always_comb begin
    bus.o_is_busy = (state_q != S_IDLE);
    bus.o_wr_en   = 1'b0;
    bus.o_wr_addr = 8'h00;
    bus.o_wr_data = 32'h0;
    case (state_q)
      S_WB_RES: begin
        bus.o_wr_en   = 1'b1;
        bus.o_wr_addr = RESULT_ADDR;
        bus.o_wr_data = 32'(res_q);
      end
      S_WB_STAT: begin
        bus.o_wr_en   = 1'b1;
        bus.o_wr_addr = STATUS_ADDR;
        bus.o_wr_data = {29'b0, ovf_w, cin_q, 1'b1};
      end
      default: begin
        bus.o_wr_en   = 1'b0;
      end
    endcase
  end

  assign bus.o_done      = done_q;
  assign bus.o_carry     = flag_carry_q;
  assign bus.o_ovf       = ovf_q;
  assign bus.o_dbg_state = state_q;

`ifdef ADDER_CTRL_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (bus.i_clear) begin
      irq_d = 1'b0;
    end
    if (state_q == S_WB_STAT) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.o_irq = irq_q;
`else
  assign bus.o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_adder_ctrl.sv
// Directed bench for adder_ctrl: cycle-exact busy/write timing, flag encoding,
// ignored restart, clear/set collision, async reset abort and the optional irq.
module tb_adder_ctrl;

  logic ACLK;
  logic ARSTn;

  adder_ctrl_if #(.DATA_W(32)) bus ();

  adder_ctrl #(
    .DATA_W      (32),
    .CHUNK_W     (8),
    .RESULT_ADDR (8'h10),
    .STATUS_ADDR (8'h04)
  ) dut (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .bus   (bus.slave)
  );

`ifdef ADDER_CTRL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  // Clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [39:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge ACLK) begin : wr_monitor
    logic [39:0] e;
    if (bus.o_wr_en === 1'b1) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = 'x;
      chk("wr_port", {bus.o_wr_addr, bus.o_wr_data}, e);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  bus.o_is_busy, 1'b0);
    chk({tag, "_wr_en"}, bus.o_wr_en,   1'b0);
    chk({tag, "_addr"},  bus.o_wr_addr, 8'h00);
    chk({tag, "_data"},  bus.o_wr_data, 32'h0);
    chk({tag, "_done"},  bus.o_done,    1'b0);
    chk({tag, "_carry"}, bus.o_carry,   1'b0);
    chk({tag, "_ovf"},   bus.o_ovf,     1'b0);
    chk({tag, "_irq"},   bus.o_irq,     1'b0);
    chk({tag, "_state"}, bus.o_dbg_state, 2'd0);
  endtask

  // Called in cycle 0 (one IDLE cycle); returns in cycle 7 after the flag checks.
  // stray_cyc: cycle in which a second start is pulsed; clear_cyc: cycle of i_clear.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] exp_res, input logic [2:0] exp_stat,
                        input int stray_cyc, input int clear_cyc);
    exp_q.push_back({8'h10, exp_res});
    exp_q.push_back({8'h04, 29'b0, exp_stat});
    bus.i_op_a  = a;
    bus.i_op_b  = b;
    bus.i_sub   = sub;
    bus.i_start = 1'b1;
    bus.i_clear = (clear_cyc == 0);
    tick();
    for (int c = 1; c <= 6; c++) begin
      bus.i_start = 1'b0;
      bus.i_clear = 1'b0;
      if (c == 1 && clear_cyc == 0) begin
        chk({tag, "_start_clear_done"}, bus.o_done, 1'b0);
        chk({tag, "_start_clear_irq"},  bus.o_irq,  1'b0);
      end
      if (c == stray_cyc) begin
        bus.i_op_a  = 32'h0000_0000;
        bus.i_op_b  = 32'h0000_0000;
        bus.i_sub   = 1'b1;
        bus.i_start = 1'b1;
      end
      if (c == clear_cyc) bus.i_clear = 1'b1;
      chk($sformatf("%s_busy_c%0d", tag, c),  bus.o_is_busy, 1'b1);
      chk($sformatf("%s_wr_en_c%0d", tag, c), bus.o_wr_en,   (c == 5 || c == 6));
      tick();
    end
    bus.i_start = 1'b0;
    bus.i_clear = 1'b0;
    chk({tag, "_busy_c7"},  bus.o_is_busy, 1'b0);
    chk({tag, "_wr_en_c7"}, bus.o_wr_en,   1'b0);
    chk({tag, "_done"},     bus.o_done,    1'b1);
    chk({tag, "_carry"},    bus.o_carry,   exp_stat[1]);
    chk({tag, "_ovf"},      bus.o_ovf,     exp_stat[2]);
    chk({tag, "_irq"},      bus.o_irq,     IRQ_EN);
    chk({tag, "_sb_empty"}, exp_q.size(),  0);
  endtask

  initial begin
    ARSTn       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_sub   = 1'b0;
    bus.i_op_a  = '0;
    bus.i_op_b  = '0;
    bus.i_clear = 1'b0;
    #1;
    check_idle_outputs("reset");
    tick();
    tick();
    ARSTn = 1'b1;
    tick();

    run_op("add_5_3",     32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 3'h1, -1, -1);
    run_op("add_carry",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 3'h3, -1, -1);
    run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 3'h5, -1, -1);
    run_op("sub_5_7",     32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 3'h1, -1, -1);
    run_op("sub_7_5",     32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 3'h3, -1, -1);
    run_op("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 3'h7, -1, -1);

    // Flags stay put across idle cycles until cleared.
    tick();
    chk("idle_hold_done", bus.o_done, 1'b1);
    chk("idle_hold_ovf",  bus.o_ovf,  1'b1);

    // Stray start in cycle 3 is dropped; clear in cycle 6 loses to completion.
    run_op("busy_start",  32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 3'h3, 3, 6);
    tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clear_done",  bus.o_done,  1'b0);
    chk("clear_carry", bus.o_carry, 1'b0);
    chk("clear_ovf",   bus.o_ovf,   1'b0);
    chk("clear_irq",   bus.o_irq,   1'b0);

    // Start and clear together in IDLE: both take effect.
    run_op("start_clear", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 3'h1, -1, 0);

    // Async reset in cycle 3 of an operation, released in cycle 5.
    bus.i_op_a  = 32'h0000_0003;
    bus.i_op_b  = 32'h0000_0004;
    bus.i_sub   = 1'b0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    tick();
    chk("pre_abort_busy", bus.o_is_busy, 1'b1);
    #2;
    ARSTn = 1'b0;
    #1;
    check_idle_outputs("abort");
    tick();
    tick();
    #2;
    ARSTn = 1'b1;
    tick();
    chk("post_abort_busy",  bus.o_is_busy, 1'b0);
    chk("post_abort_state", bus.o_dbg_state, 2'd0);

    run_op("after_abort", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 3'h1, -1, -1);

    tick();
    tick();
    chk("final_sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_ctrl.md
Name: adder_ctrl

Overview:
- Sequences the adder datapath behind the AXI4-Lite register bank.
- On a start pulse from the register bank, latches both operands and performs an add or subtract in CHUNK_W-bit slices, one slice per cycle.
- Writes the result and then a status word back into the register bank through a write port.
- Drives the busy flag that the AXI4-Lite slave uses to answer SLVERR while an operation is in flight.

Parameters:
- DATA_W, 32: operand and result width; must be a multiple of CHUNK_W.
- CHUNK_W, 8: bits added per cycle; NUM_CHUNKS = DATA_W/CHUNK_W.
- RESULT_ADDR, 8'h10: register-bank address of the RESULT register.
- STATUS_ADDR, 8'h04: register-bank address of the STATUS register.

Ports:
- ACLK  in  1  clock
- ARSTn  in  1  reset; asynchronous, active-low
- i_start  in  1  one-cycle pulse, CTRL.START written
- i_sub  in  1  operation select, 0=A+B, 1=A-B; sampled with i_start
- i_op_a  in  DATA_W  operand A; sampled with i_start
- i_op_b  in  DATA_W  operand B; sampled with i_start
- i_clear  in  1  one-cycle pulse, clears sticky status
- o_is_busy  out  1  operation in flight
- o_wr_en  out  1  register-bank write strobe
- o_wr_addr  out  8  register-bank write address
- o_wr_data  out  32  register-bank write data
- o_done  out  1  sticky: operation completed
- o_carry  out  1  sticky: carry out of MSB
- o_ovf  out  1  sticky: signed overflow
- o_irq  out  1  completion interrupt (ADDER_CTRL_IRQ_EN only)

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; all outputs 0; internal registers 0.
  - An aborted operation issues no further writes.
- States: IDLE, ADD, WB_RES, WB_STAT. All outputs are Moore-decoded from registered state or registered values.
- IDLE:
  - o_is_busy=0, o_wr_en=0.
  - i_start=1: latch a=i_op_a, b=(i_sub ? ~i_op_b : i_op_b), carry=i_sub, chunk counter k=0; next state ADD.
- ADD:
  - o_is_busy=1.
  - Each cycle: {c, res[k*CHUNK_W +: CHUNK_W]} = a_slice + b_slice + carry; carry<=c; k<=k+1.
  - After slice NUM_CHUNKS-1: next state WB_RES. ADD lasts exactly NUM_CHUNKS cycles.
- WB_RES:
  - o_is_busy=1; o_wr_en=1; o_wr_addr=RESULT_ADDR; o_wr_data=res zero-extended to 32.
  - Next state WB_STAT; single cycle, no acknowledge.
- WB_STAT:
  - o_is_busy=1; o_wr_en=1; o_wr_addr=STATUS_ADDR; o_wr_data={29'b0, ovf, carry, 1'b1}.
  - On exit: o_done<=1, o_carry<=final carry, o_ovf<=ovf; next state IDLE.
- Flag definitions:
  - ovf = (a[MSB]==b[MSB]) && (res[MSB]!=a[MSB]), with b the already-inverted operand for subtract.
  - carry is the raw carry out. For subtract, carry=1 means no borrow.
- Timing: start sampled at edge 0 → o_is_busy=1 during cycles 1..NUM_CHUNKS+2 → result write in cycle NUM_CHUNKS+1 → status write in cycle NUM_CHUNKS+2 → IDLE in cycle NUM_CHUNKS+3. For the defaults: result cycle 5, status cycle 6, idle cycle 7.
- i_start outside IDLE: ignored, not queued; no side effects.
- i_clear:
  - Clears o_done/o_carry/o_ovf in any state; never aborts an operation.
  - Same cycle as the WB_STAT exit: set wins.
- i_start and i_clear in the same IDLE cycle: both take effect.
- A new start is accepted in the first IDLE cycle after WB_STAT. Sticky flags stay unchanged until the next WB_STAT exit or an i_clear.
- Elaboration-time check fails if DATA_W % CHUNK_W != 0 or DATA_W > 32.

Optional Feature:
- Macro: ADDER_CTRL_IRQ_EN.
- Defined:
  - o_irq is set on the WB_STAT exit and held until i_clear.
  - If clear and set occur in the same cycle, set wins.
  - Reset value 0.
- Undefined: o_irq is tied to 0 and no interrupt register exists.

Test Plan:
- Basic add: A=0x00000005, B=0x00000003, sub=0, start at cycle 0.
  - Write (0x10, 0x00000008) in cycle 5; write (0x04, 0x00000001) in cycle 6; busy high cycles 1-6.
  - Afterwards o_done=1, o_carry=0, o_ovf=0.
- Add with carry and signed overflow:
  - A=0xFFFFFFFF, B=0x00000001 → RESULT 0x00000000, STATUS 0x3.
  - A=0x7FFFFFFF, B=0x00000001 → RESULT 0x80000000, STATUS 0x5.
- Subtract:
  - A=5, B=7 → RESULT 0xFFFFFFFE, STATUS 0x1 (borrow).
  - A=7, B=5 → RESULT 0x00000002, STATUS 0x3.
  - A=0x80000000, B=1 → RESULT 0x7FFFFFFF, STATUS 0x7.
- Start while busy and clear collision:
  - Second i_start in cycle 3 → ignored; exactly two writes; operands unchanged.
  - i_clear in cycle 6 (the WB_STAT cycle) → o_done=1 afterwards (set wins).
  - i_clear in cycle 8 → all sticky flags 0.
- Reset mid-operation: ARSTn low asynchronously in cycle 3, released in cycle 5.
  - All outputs 0 immediately; no o_wr_en pulse.
  - Next start A=1, B=2 → RESULT 0x00000003 at the normal latency.
- Interrupt, with ADDER_CTRL_IRQ_EN:
  - o_irq rises after the status write and holds until i_clear.
  - Without the macro, o_irq stays 0 for the whole run.
